// File: rtl/ber_checker.sv
// ber_checker: bit-error-rate checker for a 22-bit PRBS (x^22 + x^21 + 1)
// QPSK symbol stream.
//
// The local PRBS register self-synchronises from I_sym[0] (ACQUIRE), proves
// alignment over VERIFY_SYMS clean symbols (VERIFY), then counts compared bits
// and bit errors (LOCKED). Lock is dropped when one monitoring window collects
// LOSS_THRESH errors.
//
// Ports
//   clk            sole clock, rising edge
//   reset          synchronous active-high reset
//   sam_clk_ena    symbol strobe; I_sym/Q_sym sampled only when high
//   I_sym, Q_sym   received symbol bits (2 each)
//   clear_counts   synchronous clear of bit_count/err_count
//   locked         high while in LOCKED
//   state          0 = ACQUIRE, 1 = VERIFY, 2 = LOCKED
//   bit_count      bits compared while LOCKED (saturating, 40 bits)
//   err_count      bit mismatches while LOCKED (saturating, 32 bits)
//   sym_err        one-cycle pulse after a LOCKED symbol with any mismatch
//   sym_err_count  (only with BER_CHECKER_SYM_COUNT_EN) saturating count of
//                  sym_err pulses
//
// Build option: define BER_CHECKER_SYM_COUNT_EN to add sym_err_count.
//
// state   | meaning
// ACQUIRE | shift received I_sym[0] into r, 22 strobes to fill
// VERIFY  | r free-runs, VERIFY_SYMS consecutive clean symbols needed
// LOCKED  | counting bits/errors, window-based loss-of-lock detection

module ber_checker #(
  parameter int VERIFY_SYMS = 64,
  parameter int LOSS_WINDOW = 256,
  parameter int LOSS_THRESH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sam_clk_ena,
  input  logic [1:0]  I_sym,
  input  logic [1:0]  Q_sym,
  input  logic        clear_counts,
  output logic        locked,
  output logic [1:0]  state,
  output logic [39:0] bit_count,
  output logic [31:0] err_count,
  output logic        sym_err
`ifdef BER_CHECKER_SYM_COUNT_EN
  ,
  output logic [31:0] sym_err_count
`endif
);

  localparam int VW = (VERIFY_SYMS > 1) ? $clog2(VERIFY_SYMS) : 1;
  localparam int WW = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
  localparam int SW = $clog2(LOSS_THRESH + 5);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    VERIFY  = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [21:0]   r_q, r_d;
  logic [4:0]    fill_q, fill_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [SW-1:0] wsum_q, wsum_d;
  logic [39:0]   bit_q, bit_d;
  logic [31:0]   err_q, err_d;
  logic          sym_err_q, sym_err_d;

  logic [21:0]   r_next;
  logic [21:0]   r_shift;
  logic [3:0]    diff;
  logic [2:0]    errs;
  logic [SW-1:0] wsum_new;
  logic [40:0]   bit_sum;
  logic [32:0]   err_sum;

  // Free-running successor of r; its low nibble is the symbol expected now.
  assign r_next   = {r_q[20:0], r_q[21] ^ r_q[20]};
  assign r_shift  = {r_q[20:0], I_sym[0]};
  assign diff     = {I_sym, Q_sym} ^ {r_next[1:0], r_next[3:2]};
  assign errs     = {2'b00, diff[0]} + {2'b00, diff[1]}
                  + {2'b00, diff[2]} + {2'b00, diff[3]};
  assign wsum_new = wsum_q + SW'(errs);
  assign bit_sum  = {1'b0, bit_q} + 41'd4;
  assign err_sum  = {1'b0, err_q} + {30'd0, errs};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACQUIRE;
      r_q       <= '0;
      fill_q    <= '0;
      vcnt_q    <= '0;
      wcnt_q    <= '0;
      wsum_q    <= '0;
      bit_q     <= '0;
      err_q     <= '0;
      sym_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      fill_q    <= fill_d;
      vcnt_q    <= vcnt_d;
      wcnt_q    <= wcnt_d;
      wsum_q    <= wsum_d;
      bit_q     <= bit_d;
      err_q     <= err_d;
      sym_err_q <= sym_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    fill_d    = fill_q;
    vcnt_d    = vcnt_q;
    wcnt_d    = wcnt_q;
    wsum_d    = wsum_q;
    bit_d     = bit_q;
    err_d     = err_q;
    sym_err_d = 1'b0;

    if (sam_clk_ena) begin
      case (state_q)
        ACQUIRE: begin
          r_d = r_shift;
          if (fill_q == 5'd21) begin
            fill_d = '0;
            // An all-zero fill is the PRBS lock-up state; refill instead.
            if (r_shift != '0) begin
              state_d = VERIFY;
              vcnt_d  = '0;
            end
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
        VERIFY: begin
          r_d = r_next;
          if (diff != '0) begin
            state_d = ACQUIRE;
            fill_d  = '0;
            vcnt_d  = '0;
          end else if (vcnt_q == VW'(VERIFY_SYMS - 1)) begin
            state_d = LOCKED;
            vcnt_d  = '0;
            wcnt_d  = '0;
            wsum_d  = '0;
          end else begin
            vcnt_d = vcnt_q + 1'b1;
          end
        end
        LOCKED: begin
          r_d       = r_next;
          sym_err_d = (errs != 3'd0);
          bit_d     = bit_sum[40] ? '1 : bit_sum[39:0];
          err_d     = err_sum[32] ? '1 : err_sum[31:0];
          if (wsum_new >= SW'(LOSS_THRESH)) begin
            state_d = ACQUIRE;
            fill_d  = '0;
            wcnt_d  = '0;
            wsum_d  = '0;
          end else if (wcnt_q == WW'(LOSS_WINDOW - 1)) begin
            wcnt_d = '0;
            wsum_d = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
            wsum_d = wsum_new;
          end
        end
        default: begin
          state_d = ACQUIRE;
          fill_d  = '0;
        end
      endcase
    end

    // Clearing takes precedence over a coincident strobe's contribution.
    if (clear_counts) begin
      bit_d = '0;
      err_d = '0;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign state     = state_q;
  assign bit_count = bit_q;
  assign err_count = err_q;
  assign sym_err   = sym_err_q;

`ifdef BER_CHECKER_SYM_COUNT_EN
  logic [31:0] sec_q;

  always_ff @(posedge clk) begin
    if (reset || clear_counts) begin
      sec_q <= '0;
    end else if (sym_err_d && (sec_q != '1)) begin
      sec_q <= sec_q + 32'd1;
    end
  end

  assign sym_err_count = sec_q;
`endif

endmodule

// File: tb/tb_ber_checker.sv
// Directed testbench for ber_checker with default parameters. A local PRBS
// transmitter (seeded 22'h3fffff) generates the clean stream; a 4-bit mask
// {I[1],I[0],Q[1],Q[0]} flips selected bits of a symbol.
module tb_ber_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sam_clk_ena = 1'b0;
  logic [1:0]  I_sym = '0;
  logic [1:0]  Q_sym = '0;
  logic        clear_counts = 1'b0;
  logic        locked;
  logic [1:0]  state;
  logic [39:0] bit_count;
  logic [31:0] err_count;
  logic        sym_err;
`ifdef BER_CHECKER_SYM_COUNT_EN
  logic [31:0] sym_err_count;
`endif

  int total = 0;
  int bad = 0;
  logic [21:0] tx = 22'h3fffff;

  ber_checker dut (
    .clk          (clk),
    .reset        (reset),
    .sam_clk_ena  (sam_clk_ena),
    .I_sym        (I_sym),
    .Q_sym        (Q_sym),
    .clear_counts (clear_counts),
    .locked       (locked),
    .state        (state),
    .bit_count    (bit_count),
    .err_count    (err_count),
    .sym_err      (sym_err)
`ifdef BER_CHECKER_SYM_COUNT_EN
    ,
    .sym_err_count(sym_err_count)
`endif
  );

  always #5 clk = ~clk;

  // Called at a falling edge; drives one strobed symbol, returns at the next
  // falling edge with the DUT's response visible.
  task automatic sym(input logic [3:0] mask);
    logic [21:0] n;
    n = {tx[20:0], tx[21] ^ tx[20]};
    tx = n;
    sam_clk_ena = 1'b1;
    I_sym = n[1:0] ^ mask[3:2];
    Q_sym = n[3:2] ^ mask[1:0];
    @(negedge clk);
    sam_clk_ena = 1'b0;
  endtask

  task automatic clean(input int cnt);
    for (int i = 0; i < cnt; i++) sym(4'b0000);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic lock_up();
    do_reset();
    clean(86);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got %0d want 0", state); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got %0b want 0", locked); end
    total++; if (bit_count !== 40'd0) begin bad++; $display("FAIL reset_bits got %0d want 0", bit_count); end
    total++; if (err_count !== 32'd0) begin bad++; $display("FAIL reset_errs got %0d want 0", err_count); end
    total++; if (sym_err !== 1'b0) begin bad++; $display("FAIL reset_sym_err got %0b want 0", sym_err); end
  endtask

  task automatic test_zero_input();
    sam_clk_ena = 1'b1;
    I_sym = '0;
    Q_sym = '0;
    repeat (100) @(negedge clk);
    sam_clk_ena = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL zero_state got %0d want 0", state); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL zero_locked got %0b want 0", locked); end
    total++; if (bit_count !== 40'd0) begin bad++; $display("FAIL zero_bits got %0d want 0", bit_count); end
    total++; if (err_count !== 32'd0) begin bad++; $display("FAIL zero_errs got %0d want 0", err_count); end
  endtask

  task automatic test_lock();
    do_reset();
    clean(22);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL fill_to_verify got %0d want 1", state); end
    clean(63);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early got %0b want 0", locked); end
    total++; if (state !== 2'd1) begin bad++; $display("FAIL lock_verify_state got %0d want 1", state); end
    clean(1);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_at_86 got %0b want 1", locked); end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL lock_state got %0d want 2", state); end
    total++; if (bit_count !== 40'd0) begin bad++; $display("FAIL lock_bits0 got %0d want 0", bit_count); end
    clean(10);
    total++; if (bit_count !== 40'd40) begin bad++; $display("FAIL lock_bits40 got %0d want 40", bit_count); end
    total++; if (err_count !== 32'd0) begin bad++; $display("FAIL lock_errs got %0d want 0", err_count); end
  endtask

  task automatic test_single_error();
    sym(4'b1000);
    total++; if (err_count !== 32'd1) begin bad++; $display("FAIL single_errs got %0d want 1", err_count); end
    total++; if (bit_count !== 40'd44) begin bad++; $display("FAIL single_bits got %0d want 44", bit_count); end
    total++; if (sym_err !== 1'b1) begin bad++; $display("FAIL single_pulse got %0b want 1", sym_err); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL single_locked got %0b want 1", locked); end
    clean(1);
    total++; if (sym_err !== 1'b0) begin bad++; $display("FAIL single_pulse_end got %0b want 0", sym_err); end
    clean(4);
    total++; if (err_count !== 32'd1) begin bad++; $display("FAIL single_r_intact got %0d want 1", err_count); end
    total++; if (bit_count !== 40'd64) begin bad++; $display("FAIL single_bits64 got %0d want 64", bit_count); end
  endtask

  task automatic test_no_strobe();
    I_sym = 2'b11;
    Q_sym = 2'b01;
    repeat (7) @(negedge clk);
    total++; if (bit_count !== 40'd64) begin bad++; $display("FAIL hold_bits got %0d want 64", bit_count); end
    clean(3);
    total++; if (err_count !== 32'd1) begin bad++; $display("FAIL hold_resume_errs got %0d want 1", err_count); end
    total++; if (bit_count !== 40'd76) begin bad++; $display("FAIL hold_resume_bits got %0d want 76", bit_count); end
  endtask

  task automatic test_clear();
    clear_counts = 1'b1;
    sym(4'b0001);
    clear_counts = 1'b0;
    total++; if (bit_count !== 40'd0) begin bad++; $display("FAIL clear_bits got %0d want 0", bit_count); end
    total++; if (err_count !== 32'd0) begin bad++; $display("FAIL clear_errs got %0d want 0", err_count); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL clear_locked got %0b want 1", locked); end
    clean(1);
    total++; if (bit_count !== 40'd4) begin bad++; $display("FAIL clear_after_bits got %0d want 4", bit_count); end
    total++; if (err_count !== 32'd0) begin bad++; $display("FAIL clear_after_errs got %0d want 0", err_count); end
  endtask

  task automatic test_reset_midlock();
    reset = 1'b1;
    clear_counts = 1'b1;
    sam_clk_ena = 1'b1;
    I_sym = 2'b10;
    Q_sym = 2'b01;
    @(negedge clk);
    reset = 1'b0;
    clear_counts = 1'b0;
    sam_clk_ena = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_mid_state got %0d want 0", state); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_mid_locked got %0b want 0", locked); end
    total++; if (bit_count !== 40'd0) begin bad++; $display("FAIL rst_mid_bits got %0d want 0", bit_count); end
    total++; if (err_count !== 32'd0) begin bad++; $display("FAIL rst_mid_errs got %0d want 0", err_count); end
    total++; if (sym_err !== 1'b0) begin bad++; $display("FAIL rst_mid_sym_err got %0b want 0", sym_err); end
    clean(85);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL relock_early got %0b want 0", locked); end
    clean(1);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock_at_86 got %0b want 1", locked); end
  endtask

  task automatic test_window();
    for (int i = 0; i < 7; i++) sym(4'b1111);
    for (int i = 0; i < 3; i++) sym(4'b0001);
    total++; if (err_count !== 32'd31) begin bad++; $display("FAIL win_errs31 got %0d want 31", err_count); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL win_below_thresh got %0b want 1", locked); end
    clean(246);
    sym(4'b0100);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL win_restart_locked got %0b want 1", locked); end
    total++; if (err_count !== 32'd32) begin bad++; $display("FAIL win_errs32 got %0d want 32", err_count); end
  endtask

  task automatic test_loss();
    lock_up();
    for (int i = 0; i < 7; i++) sym(4'b1111);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL loss_pre_state got %0d want 2", state); end
    total++; if (err_count !== 32'd28) begin bad++; $display("FAIL loss_pre_errs got %0d want 28", err_count); end
    sym(4'b1111);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL loss_state got %0d want 0", state); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL loss_locked got %0b want 0", locked); end
    total++; if (err_count !== 32'd32) begin bad++; $display("FAIL loss_errs got %0d want 32", err_count); end
    total++; if (bit_count !== 40'd32) begin bad++; $display("FAIL loss_bits got %0d want 32", bit_count); end
    sym(4'b1111);
    sym(4'b1111);
    total++; if (err_count !== 32'd32) begin bad++; $display("FAIL loss_hold_errs got %0d want 32", err_count); end
    total++; if (bit_count !== 40'd32) begin bad++; $display("FAIL loss_hold_bits got %0d want 32", bit_count); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_zero_input();
    test_lock();
    test_single_error();
    test_no_strobe();
    test_clear();
    test_reset_midlock();
    test_window();
    test_loss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
